cbuf_rd_sequencer: RTL and testbench

CBUF_RD_SEQUENCER -- requirements
Module: cbuf_rd_sequencer

---
 rtl/cbuf_rd_sequencer.sv | 122 ++++++++++++
 tb/tb_cbuf_rd_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbuf_rd_sequencer.sv
// Circular-buffer readout sequencer: pops a trigger address, waits for the waveform
// to be fully written, then streams it out with an RD_LATENCY-deep qualify pipeline.
module cbuf_rd_sequencer #(
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned GUARD      = 16
) (
    input  logic        adc_clk,
    input  logic        reset_clk_adc_n,
    input  logic        cbuf_rd_en,
    input  logic [13:0] async_num_bursts,
    input  logic [15:0] async_pre_trig,
    input  logic [15:0] circ_buf_wr_addr,
    input  logic        trig_fifo_empty,
    input  logic [15:0] circ_buf_trig_addr,
    input  logic        out_almost_full,
    output logic        trig_addr_rd_en,
    output logic [15:0] circ_buf_rd_addr,
    output logic        rd_dat_valid,
    output logic        rd_first,
    output logic        rd_last,
    output logic        wfm_done,
    output logic        cbuf_rd_trig_wait,
    output logic        overrun_err
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        WAIT_DATA,
        STREAM,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [15:0] rd_ptr;
    logic [15:0] n_words;
    logic [15:0] remaining;
    logic [RD_LATENCY-1:0] pipe_v, pipe_f, pipe_l;
    logic armed;
    logic done_r;
    logic overrun_r;

    logic [15:0] load_start;
    logic [15:0] load_n;
    logic [15:0] ahead;
    logic issue, issue_first, issue_last;
    logic drain_done;
    logic lapped;

    always_comb begin
        load_start  = circ_buf_trig_addr - async_pre_trig;
        load_n      = {async_num_bursts, 2'b00};
        // rd_ptr still equals the waveform start while in WAIT_DATA, so one distance serves both checks
        ahead       = circ_buf_wr_addr - rd_ptr;
        issue       = (state == STREAM) && !out_almost_full;
        issue_first = issue && (remaining == n_words);
        issue_last  = issue && (remaining == 16'd1);
        drain_done  = ((pipe_v << 1) == '0);
        lapped      = ((state == WAIT_DATA) || (state == STREAM)) &&
                      (32'(ahead) > 32'(65536 - GUARD));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (armed && cbuf_rd_en && !trig_fifo_empty) state_nxt = POP;
            POP:       state_nxt = LOAD;
            LOAD:      state_nxt = (load_n == '0) ? IDLE : WAIT_DATA;
            WAIT_DATA: if (ahead >= n_words) state_nxt = STREAM;
            STREAM:    if (issue_last) state_nxt = DRAIN;
            DRAIN:     if (drain_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (!reset_clk_adc_n) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            n_words   <= '0;
            remaining <= '0;
            pipe_v    <= '0;
            pipe_f    <= '0;
            pipe_l    <= '0;
            armed     <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            armed     <= 1'b1;
            pipe_v    <= (pipe_v << 1) | RD_LATENCY'(issue);
            pipe_f    <= (pipe_f << 1) | RD_LATENCY'(issue_first);
            pipe_l    <= (pipe_l << 1) | RD_LATENCY'(issue_last);
            // registered so the pulse lands one cycle after the final valid word
            done_r    <= ((state == LOAD) && (load_n == '0)) ||
                         ((state == DRAIN) && drain_done);
            overrun_r <= overrun_r | lapped;
            if (state == LOAD) begin
                rd_ptr    <= load_start;
                n_words   <= load_n;
                remaining <= load_n;
            end else if (issue) begin
                rd_ptr    <= rd_ptr + 16'd1;
                remaining <= remaining - 16'd1;
            end
        end
    end

    always_comb begin
        trig_addr_rd_en   = (state == POP);
        circ_buf_rd_addr  = rd_ptr;
        rd_dat_valid      = pipe_v[RD_LATENCY-1];
        rd_first          = pipe_f[RD_LATENCY-1];
        rd_last           = pipe_l[RD_LATENCY-1];
        wfm_done          = done_r;
        cbuf_rd_trig_wait = (state == IDLE) && armed && cbuf_rd_en && trig_fifo_empty;
        overrun_err       = overrun_r;
    end

endmodule

// File: tb/tb_cbuf_rd_sequencer.sv
// Scoreboard bench for cbuf_rd_sequencer: a trigger-FIFO model feeds the DUT, expected
// words are queued at each pop and compared by a negedge monitor.
module tb_cbuf_rd_sequencer;

    localparam int unsigned LAT = 3;

    logic        adc_clk;
    logic        reset_clk_adc_n;
    logic        cbuf_rd_en;
    logic [13:0] async_num_bursts;
    logic [15:0] async_pre_trig;
    logic [15:0] circ_buf_wr_addr;
    logic        trig_fifo_empty;
    logic [15:0] circ_buf_trig_addr;
    logic        out_almost_full;
    logic        trig_addr_rd_en;
    logic [15:0] circ_buf_rd_addr;
    logic        rd_dat_valid;
    logic        rd_first;
    logic        rd_last;
    logic        wfm_done;
    logic        cbuf_rd_trig_wait;
    logic        overrun_err;

    cbuf_rd_sequencer #(.RD_LATENCY(LAT), .GUARD(16)) dut (
        .adc_clk           (adc_clk),
        .reset_clk_adc_n   (reset_clk_adc_n),
        .cbuf_rd_en        (cbuf_rd_en),
        .async_num_bursts  (async_num_bursts),
        .async_pre_trig    (async_pre_trig),
        .circ_buf_wr_addr  (circ_buf_wr_addr),
        .trig_fifo_empty   (trig_fifo_empty),
        .circ_buf_trig_addr(circ_buf_trig_addr),
        .out_almost_full   (out_almost_full),
        .trig_addr_rd_en   (trig_addr_rd_en),
        .circ_buf_rd_addr  (circ_buf_rd_addr),
        .rd_dat_valid      (rd_dat_valid),
        .rd_first          (rd_first),
        .rd_last           (rd_last),
        .wfm_done          (wfm_done),
        .cbuf_rd_trig_wait (cbuf_rd_trig_wait),
        .overrun_err       (overrun_err)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    typedef struct {
        bit          done;
        logic [15:0] addr;
        bit          first;
        bit          last;
        int          n;
        int          pop_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] fifo_q[$];
    logic [15:0] hist[0:63];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pops = 0;
    int dones = 0;
    int last_valid_cyc = -100;
    int first_valid_cyc = -100;
    int last_pop_cyc = -100;
    int last_done_cyc = -100;
    int wr_zero_cyc = -100;
    int af_mode = 0;
    bit wr_step = 0;
    bit sb_off = 0;
    bit prev_rd_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a waveform is N = 4*bursts consecutive words from trig-pre, then one done.
    function automatic void push_expect(input logic [15:0] trig, input logic [15:0] pre,
                                        input logic [13:0] bursts, input int pc);
        exp_t e;
        logic [15:0] start;
        int n;
        start = trig - pre;
        n = int'(bursts) * 4;
        for (int i = 0; i < n; i++) begin
            e.done = 0; e.addr = start + 16'(i); e.first = (i == 0); e.last = (i == n - 1);
            e.n = n; e.pop_cyc = pc;
            exp_q.push_back(e);
        end
        e.done = 1; e.addr = '0; e.first = 0; e.last = 0; e.n = n; e.pop_cyc = pc;
        exp_q.push_back(e);
    endfunction

    // Monitor, FIFO model and background input drivers, all on the falling edge.
    initial begin
        logic [15:0] t;
        exp_t e;
        forever begin
            @(negedge adc_clk);
            cyc++;
            hist[cyc % 64] = circ_buf_rd_addr;
            if (trig_addr_rd_en) begin
                check("pop_single_cycle", 32'(prev_rd_en), 0);
                pops++;
                last_pop_cyc = cyc;
                if (fifo_q.size() > 0) begin
                    t = fifo_q.pop_front();
                    circ_buf_trig_addr = t;
                    trig_fifo_empty = (fifo_q.size() == 0);
                    push_expect(t, async_pre_trig, async_num_bursts, cyc);
                end else begin
                    tests++; fails++;
                    $display("FAIL pop_empty_fifo: pop seen with fifo depth 0, expected none (cycle %0d)", cyc);
                end
            end
            prev_rd_en = trig_addr_rd_en;
            if (!sb_off && rd_dat_valid) begin
                if (exp_q.size() == 0 || exp_q[0].done) begin
                    tests++; fails++;
                    $display("FAIL valid_unexpected: rd_dat_valid=1 addr 0x%0h, expected no valid (cycle %0d)",
                             hist[(cyc - LAT) % 64], cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_addr", 32'(hist[(cyc - LAT) % 64]), 32'(e.addr));
                    check("rd_first", 32'(rd_first), 32'(e.first));
                    check("rd_last", 32'(rd_last), 32'(e.last));
                    if (e.first) first_valid_cyc = cyc;
                    last_valid_cyc = cyc;
                end
            end
            if (!sb_off && wfm_done) begin
                dones++;
                last_done_cyc = cyc;
                if (exp_q.size() == 0 || !exp_q[0].done) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected: wfm_done=1 with %0d words outstanding, expected 0 (cycle %0d)",
                             exp_q.size(), cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.n == 0) check("done_timing_n0", 32'(cyc), 32'(e.pop_cyc + 2));
                    else          check("done_timing", 32'(cyc), 32'(last_valid_cyc + 1));
                end
            end
            case (af_mode)
                0:       out_almost_full = 1'b0;
                1:       out_almost_full = ($urandom_range(0, 2) == 0);
                default: out_almost_full = !out_almost_full;
            endcase
            if (wr_step) begin
                circ_buf_wr_addr = circ_buf_wr_addr + 16'd1;
                if (circ_buf_wr_addr == 16'h0000) wr_zero_cyc = cyc;
            end
        end
    end

    task automatic push_trig(input logic [15:0] a);
        fifo_q.push_back(a);
        trig_fifo_empty = 1'b0;
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            if (dones >= target) break;
            @(negedge adc_clk);
        end
        check(name, 32'(dones >= target), 1);
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            if (pops >= target) break;
            @(negedge adc_clk);
        end
        check(name, 32'(pops >= target), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},    32'(trig_addr_rd_en), 0);
        check({tag, "_valid"},    32'(rd_dat_valid), 0);
        check({tag, "_first"},    32'(rd_first), 0);
        check({tag, "_last"},     32'(rd_last), 0);
        check({tag, "_done"},     32'(wfm_done), 0);
        check({tag, "_trigwait"}, 32'(cbuf_rd_trig_wait), 0);
        check({tag, "_overrun"},  32'(overrun_err), 0);
        check({tag, "_rd_addr"},  32'(circ_buf_rd_addr), 0);
    endtask

    initial begin
        int p0, d0, d1;
        logic [15:0] trig, pre, start;
        int nb;
        reset_clk_adc_n    = 1'b0;
        cbuf_rd_en         = 1'b0;
        async_num_bursts   = '0;
        async_pre_trig     = '0;
        circ_buf_wr_addr   = '0;
        trig_fifo_empty    = 1'b1;
        circ_buf_trig_addr = '0;
        out_almost_full    = 1'b0;
        repeat (3) @(negedge adc_clk);
        check_all_zero("reset");

        // Trigger pending and enabled while still in reset: no pop during reset or the cycle after release
        async_pre_trig = 16'h0020; async_num_bursts = 14'd2; circ_buf_wr_addr = 16'h1100;
        push_trig(16'h1000);
        cbuf_rd_en = 1'b1;
        repeat (2) @(negedge adc_clk);
        check("reset_no_pop", 32'(trig_addr_rd_en), 0);
        check("reset_trigwait", 32'(cbuf_rd_trig_wait), 0);
        reset_clk_adc_n = 1'b1;
        @(negedge adc_clk);
        check("release_no_pop", 32'(trig_addr_rd_en), 0);
        wait_dones(1, 100, "basic_done");
        repeat (2) @(negedge adc_clk);
        check("basic_pops", 32'(pops), 1);
        check("basic_sb_empty", 32'(exp_q.size()), 0);
        check("idle_trigwait", 32'(cbuf_rd_trig_wait), 1);

        // Start wraps below zero; hold until the writer reaches 0x0000
        circ_buf_wr_addr = 16'hFFFC; async_pre_trig = 16'h0008; async_num_bursts = 14'd1;
        p0 = pops; d0 = dones;
        push_trig(16'h0004);
        wait_pops(p0 + 1, 50, "wrap_pop");
        repeat (3) @(negedge adc_clk);
        wr_step = 1;
        wait_dones(d0 + 1, 100, "wrap_done");
        wr_step = 0;
        check("wrap_wait_data", 32'(first_valid_cyc), 32'(wr_zero_cyc + 1 + int'(LAT)));

        // Backpressure every other cycle
        circ_buf_wr_addr = 16'h4000; async_pre_trig = 16'h0010; async_num_bursts = 14'd4;
        af_mode = 2; d0 = dones;
        push_trig(16'h3000);
        wait_dones(d0 + 1, 200, "bp_done");
        af_mode = 0;
        check("bp_sb_empty", 32'(exp_q.size()), 0);

        // Disable mid-waveform with a second trigger queued
        circ_buf_wr_addr = 16'h6000; async_pre_trig = 16'h0000; async_num_bursts = 14'd2;
        p0 = pops; d0 = dones;
        push_trig(16'h5000); push_trig(16'h5100);
        wait_pops(p0 + 1, 50, "dis_pop");
        cbuf_rd_en = 1'b0;
        wait_dones(d0 + 1, 100, "dis_done");
        repeat (8) @(negedge adc_clk);
        check("dis_pops", 32'(pops), 32'(p0 + 1));
        check("dis_fifo_depth", 32'(fifo_q.size()), 1);
        check("dis_trigwait", 32'(cbuf_rd_trig_wait), 0);
        cbuf_rd_en = 1'b1;
        wait_dones(d0 + 2, 100, "dis_second_done");

        // Back-to-back triggers: second pop immediately after wfm_done
        p0 = pops; d0 = dones;
        push_trig(16'h5200); push_trig(16'h5300);
        wait_dones(d0 + 1, 100, "b2b_first_done");
        d1 = last_done_cyc;
        wait_pops(p0 + 2, 20, "b2b_pop");
        check("b2b_pop_timing", 32'(last_pop_cyc), 32'(d1 + 1));
        wait_dones(d0 + 2, 100, "b2b_second_done");

        // Zero-length waveform
        async_num_bursts = 14'd0; p0 = pops; d0 = dones;
        push_trig(16'h5400);
        wait_dones(d0 + 1, 50, "zero_done");
        repeat (3) @(negedge adc_clk);
        check("zero_pops", 32'(pops), 32'(p0 + 1));

        // Randomized waveforms; length/pretrigger scrambled once loaded
        af_mode = 1;
        for (int w = 0; w < 20; w++) begin
            trig = 16'($urandom); pre = 16'($urandom); nb = $urandom_range(0, 6);
            start = trig - pre;
            async_pre_trig = pre; async_num_bursts = 14'(nb);
            circ_buf_wr_addr = start + 16'(nb * 4) + 16'($urandom_range(0, 200));
            p0 = pops; d0 = dones;
            push_trig(trig);
            wait_pops(p0 + 1, 50, "rand_pop");
            repeat (2) @(negedge adc_clk);
            async_pre_trig = 16'($urandom); async_num_bursts = 14'($urandom);
            wait_dones(d0 + 1, 200, "rand_done");
        end
        af_mode = 0;
        check("rand_sb_empty", 32'(exp_q.size()), 0);
        check("no_overrun", 32'(overrun_err), 0);

        // Writer just behind the reader: overrun flags but streaming completes
        circ_buf_wr_addr = 16'h1FFB; async_pre_trig = 16'h0000; async_num_bursts = 14'd1;
        d0 = dones;
        push_trig(16'h2000);
        wait_dones(d0 + 1, 100, "ovr_done");
        check("overrun_set", 32'(overrun_err), 1);
        repeat (5) @(negedge adc_clk);
        check("overrun_sticky", 32'(overrun_err), 1);

        // Reset mid-stream
        circ_buf_wr_addr = 16'h8000; async_num_bursts = 14'd8;
        push_trig(16'h7000);
        for (int k = 0; k < 100; k++) begin
            if (rd_dat_valid) break;
            @(negedge adc_clk);
        end
        check("midstream_reached", 32'(rd_dat_valid), 1);
        sb_off = 1;
        exp_q.delete();
        reset_clk_adc_n = 1'b0;
        cbuf_rd_en = 1'b0;
        @(negedge adc_clk);
        check_all_zero("midreset");
        reset_clk_adc_n = 1'b1;
        async_num_bursts = 14'd1;
        p0 = pops;
        push_trig(16'h7100);
        repeat (6) @(negedge adc_clk);
        check("post_reset_no_pop", 32'(pops), 32'(p0));
        check("post_reset_trigwait", 32'(cbuf_rd_trig_wait), 0);
        sb_off = 0;
        d0 = dones;
        cbuf_rd_en = 1'b1;
        wait_dones(d0 + 1, 100, "post_reset_done");
        check("post_reset_pops", 32'(pops), 32'(p0 + 1));
        check("final_sb_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
